qm_pipe_chain: RTL and testbench

- Parametrised N-stage in-order pipeline register chain for the q3kmips core.
- Holds a valid bit and a WIDTH-bit payload per stage, and replaces hand-written inter-stage register blocks (FD, DE, EM, ...).
- Adds per-stage stall with upstream propagation, bubble insertion, per-stage flush, output backpressure and saturating stall/bubble performance counters.
- Sits between the stage datapaths (fetch/decode/execute/...) and the hazard/control logic, which drives stall_req and flush.

---
 rtl/qm_pipe_chain.sv | 94 +++++++++
 tb/tb_qm_pipe_chain.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/qm_pipe_chain.sv
// N-stage in-order pipeline register chain with per-stage stall, flush,
// output backpressure and saturating stall/bubble counters.
module qm_pipe_chain #(
  parameter int STAGES = 3,
  parameter int WIDTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall_req,
  input  logic [STAGES-1:0]        flush,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*WIDTH-1:0]  stage_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  // Handshake: an entry moves across a boundary only at a rising edge where the
  // sender's valid and the receiver's ready are both high; valid never depends on ready.
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] up_hold;
  logic [WIDTH-1:0]  up_data [STAGES];
  logic              any_stall;
  logic              any_bubble;

  // A stage holds on its own request, or when it is occupied and the stage ahead holds.
  always_comb begin : hold_chain
    logic h;
    h    = ~out_ready;
    hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      h       = stall_req[i] | (valid_q[i] & h);
      hold[i] = h;
    end
  end

  // What each stage would load on advance; a flushed upstream entry is not forwarded.
  always_comb begin
    up_valid    = '0;
    up_hold     = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = valid_q[i-1] & ~flush[i-1];
      up_hold[i]  = hold[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  assign in_ready   = ~hold[0];
  assign any_stall  = (|stall_req) | (out_valid & ~out_ready);
  assign any_bubble = |(up_hold & ~hold & ~flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush[i]) begin
          valid_q[i] <= 1'b0;
        end else if (!hold[i]) begin
          // Upstream holding means this stage takes a bubble and keeps its payload.
          valid_q[i] <= up_valid[i] & ~up_hold[i];
          if (!up_hold[i]) data_q[i] <= up_data[i];
        end
      end
      if (any_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (any_bubble && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];

endmodule

// File: tb/tb_qm_pipe_chain.sv
// Directed table-driven bench for qm_pipe_chain (3 stages, 8-bit payload,
// 2-bit counters so saturation is reachable quickly).
module tb_qm_pipe_chain;

  localparam int STAGES = 3;
  localparam int WIDTH  = 8;
  localparam int CNT_W  = 2;

  logic                    clk;
  logic                    reset;
  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic                    in_ready;
  logic [STAGES-1:0]       stall_req;
  logic [STAGES-1:0]       flush;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        bubble_cnt;

  qm_pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
    .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] d;
    logic [2:0]       stall;
    logic [2:0]       fl;
    logic             ordy;
    logic             ir;   // in_ready before the edge (not checked on reset rows)
    logic [2:0]       sv;   // stage_valid after the edge
    logic [WIDTH-1:0] od;   // out_data after the edge, checked when sv[2]
    int               st;
    int               bu;
  } vec_t;

  vec_t vecs[$];
  int   tests_run = 0;
  int   fails     = 0;

  task automatic add(input logic rst, input logic iv, input logic [7:0] d,
                     input logic [2:0] stall, input logic [2:0] fl, input logic ordy,
                     input logic ir, input logic [2:0] sv, input logic [7:0] od,
                     input int st, input int bu);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.stall = stall; v.fl = fl; v.ordy = ordy;
    v.ir = ir; v.sv = sv; v.od = od; v.st = st; v.bu = bu;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic iv, input logic [7:0] d,
                       input logic [2:0] stall, input logic [2:0] fl, input logic ordy);
    reset = rst; in_valid = iv; in_data = d; stall_req = stall; flush = fl; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; stall_req = '0; flush = '0; out_ready = 1'b1;

    //   rst iv d      stall   flush   ordy ir sv      od     st bu
    // streaming, latency and throughput
    add(1, 0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    add(0, 1, 8'h01, 3'b000, 3'b000, 1, 1, 3'b001, 8'h00, 0, 0);
    add(0, 1, 8'h02, 3'b000, 3'b000, 1, 1, 3'b011, 8'h00, 0, 0);
    add(0, 1, 8'h03, 3'b000, 3'b000, 1, 1, 3'b111, 8'h01, 0, 0);
    add(0, 1, 8'h04, 3'b000, 3'b000, 1, 1, 3'b111, 8'h02, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b110, 8'h03, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b100, 8'h04, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 8'h00, 0, 0);
    // mid-stage stall: stage 2 takes bubbles, upstream holds
    add(1, 0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    add(0, 1, 8'h10, 3'b000, 3'b000, 1, 1, 3'b001, 8'h00, 0, 0);
    add(0, 1, 8'h11, 3'b000, 3'b000, 1, 1, 3'b011, 8'h00, 0, 0);
    add(0, 1, 8'h12, 3'b000, 3'b000, 1, 1, 3'b111, 8'h10, 0, 0);
    add(0, 1, 8'h13, 3'b010, 3'b000, 1, 0, 3'b011, 8'h00, 1, 1);
    add(0, 1, 8'h13, 3'b010, 3'b000, 1, 0, 3'b011, 8'h00, 2, 2);
    add(0, 1, 8'h13, 3'b000, 3'b000, 1, 1, 3'b111, 8'h11, 2, 2);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b110, 8'h12, 2, 2);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b100, 8'h13, 2, 2);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 8'h00, 2, 2);
    // output backpressure on a full pipe
    add(1, 0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    add(0, 1, 8'h21, 3'b000, 3'b000, 1, 1, 3'b001, 8'h00, 0, 0);
    add(0, 1, 8'h22, 3'b000, 3'b000, 1, 1, 3'b011, 8'h00, 0, 0);
    add(0, 1, 8'h23, 3'b000, 3'b000, 1, 1, 3'b111, 8'h21, 0, 0);
    add(0, 1, 8'h24, 3'b000, 3'b000, 0, 0, 3'b111, 8'h21, 1, 0);
    add(0, 1, 8'h24, 3'b000, 3'b000, 0, 0, 3'b111, 8'h21, 2, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b110, 8'h22, 2, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b100, 8'h23, 2, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 8'h00, 2, 0);
    // flush of stage 1: 0xAA must never reach the output
    add(1, 0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    add(0, 1, 8'hAA, 3'b000, 3'b000, 1, 1, 3'b001, 8'h00, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b010, 8'h00, 0, 0);
    add(0, 1, 8'hBB, 3'b000, 3'b010, 1, 1, 3'b001, 8'h00, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b010, 8'h00, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b100, 8'hBB, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 8'h00, 0, 0);
    // stall and flush on the last stage together
    add(1, 0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    add(0, 1, 8'h31, 3'b000, 3'b000, 1, 1, 3'b001, 8'h00, 0, 0);
    add(0, 1, 8'h32, 3'b000, 3'b000, 1, 1, 3'b011, 8'h00, 0, 0);
    add(0, 1, 8'h33, 3'b000, 3'b000, 1, 1, 3'b111, 8'h31, 0, 0);
    add(0, 1, 8'h34, 3'b100, 3'b100, 1, 0, 3'b011, 8'h00, 1, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b110, 8'h32, 1, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b100, 8'h33, 1, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 8'h00, 1, 0);
    // counter saturation, then reset in the middle of a stall
    add(1, 0, 8'h00, 3'b000, 3'b000, 1, 0, 3'b000, 8'h00, 0, 0);
    add(0, 1, 8'h41, 3'b000, 3'b000, 1, 1, 3'b001, 8'h00, 0, 0);
    add(0, 1, 8'h42, 3'b000, 3'b000, 1, 1, 3'b011, 8'h00, 0, 0);
    add(0, 1, 8'h43, 3'b000, 3'b000, 1, 1, 3'b111, 8'h41, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 3'b111, 8'h41, 1, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 3'b111, 8'h41, 2, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 3'b111, 8'h41, 3, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 3'b111, 8'h41, 3, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 3'b111, 8'h41, 3, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 0, 0, 3'b111, 8'h41, 3, 0);
    add(1, 0, 8'h00, 3'b000, 3'b000, 0, 0, 3'b000, 8'h00, 0, 0);
    add(0, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].stall, vecs[i].fl, vecs[i].ordy);
      if (!vecs[i].rst) check("in_ready", i, 32'(in_ready), 32'(vecs[i].ir));
      tick();
      check("stage_valid", i, 32'(stage_valid), 32'(vecs[i].sv));
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].sv[2]));
      if (vecs[i].sv[2]) check("out_data", i, 32'(out_data), 32'(vecs[i].od));
      check("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].st));
      check("bubble_cnt", i, 32'(bubble_cnt), 32'(vecs[i].bu));
    end

    // Hand sequence: a bubble ahead of a stalled output is squeezed out.
    drive(1, 0, 8'h00, 3'b000, 3'b000, 1); tick();
    drive(0, 1, 8'h51, 3'b000, 3'b000, 1); tick();
    drive(0, 0, 8'h00, 3'b000, 3'b000, 1); tick();
    drive(0, 0, 8'h00, 3'b000, 3'b000, 1); tick();
    check("squeeze_start_valid", 100, 32'(stage_valid), 32'h4);
    drive(0, 1, 8'h52, 3'b000, 3'b000, 0);
    check("squeeze_ready_a", 101, 32'(in_ready), 32'h1);
    tick();
    check("squeeze_valid_a", 101, 32'(stage_valid), 32'h5);
    drive(0, 1, 8'h53, 3'b000, 3'b000, 0);
    check("squeeze_ready_b", 102, 32'(in_ready), 32'h1);
    tick();
    check("squeeze_valid_b", 102, 32'(stage_valid), 32'h7);
    drive(0, 1, 8'h54, 3'b000, 3'b000, 0);
    check("squeeze_ready_c", 103, 32'(in_ready), 32'h0);
    tick();
    check("squeeze_valid_c", 103, 32'(stage_valid), 32'h7);
    check("squeeze_data_s0", 103, 32'(stage_data[7:0]), 32'h53);
    check("squeeze_data_s1", 103, 32'(stage_data[15:8]), 32'h52);
    check("squeeze_data_s2", 103, 32'(stage_data[23:16]), 32'h51);
    check("squeeze_stall_cnt", 103, 32'(stall_cnt), 32'h3);
    check("squeeze_bubble_cnt", 103, 32'(bubble_cnt), 32'h0);
    drive(0, 0, 8'h00, 3'b000, 3'b000, 1); tick();
    check("squeeze_drain_a", 104, 32'(out_data), 32'h52);
    tick();
    check("squeeze_drain_b", 105, 32'(out_data), 32'h53);
    tick();
    check("squeeze_empty", 106, 32'(stage_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
